state_publish_arb: RTL and testbench
====================================

STATE_PUBLISH_ARB -- requirements
Module: state_publish_arb

Interface
REQ-001 The block SHALL have parameter BITS, default 8, giving the width of each published state word.
REQ-002 The block SHALL have parameter NREQ, default 3, giving the number of requesters (legal 2..8).
REQ-003 The block SHALL have parameter HOLD, default 4, giving the minimum stable cycles per published word (legal 2..255).
REQ-004 The block SHALL have port clk_50  input  1  CLOCK_50-domain clock; the only clock.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous to clk_50 and active-low.
REQ-006 The block SHALL have port req  input  NREQ  per-requester publish request, level-sensitive.
REQ-007 The block SHALL have port req_data  input  NREQ*BITS  per-requester word; slice i is [i*BITS +: BITS].
REQ-008 The block SHALL have port gnt  output  NREQ  one-hot, single-cycle grant pulse.
REQ-009 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have port state_out  output  BITS  registered published word, to be fed to the VGA-domain state synchronizer.
REQ-011 The block SHALL have port upd_toggle  output  1  flips on every publish, for cross-domain change detection.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and HOLD.
REQ-013 In IDLE with any req bit high, the block SHALL select a winner i by round-robin, searching from ptr upward modulo NREQ.
REQ-014 On the next edge the block SHALL load state_out with req_data slice i and pulse gnt[i] high for exactly that one cycle.
REQ-015 On that same edge the block SHALL invert upd_toggle, enter HOLD, and load cnt with HOLD-1.
REQ-016 On that same edge the block SHALL set ptr to (i+1) mod NREQ.
REQ-017 In HOLD, cnt SHALL decrement once per cycle; when cnt==0 the FSM SHALL return to IDLE on the next edge.
REQ-018 The FSM SHALL spend exactly HOLD cycles in HOLD, so state_out is stable for at least HOLD+1 cycles between changes.
REQ-019 Requests arriving during HOLD SHALL NOT be granted; they SHALL be evaluated in the first IDLE cycle.
REQ-020 A requester SHALL hold req and its data until gnt; req dropped before grant is a legal withdrawal, and the block SHALL NOT publish it.
REQ-021 A requester keeping req high after gnt SHALL be treated as a new request, at lowest priority relative to ptr.
REQ-022 A request arriving in the same cycle the FSM re-enters IDLE SHALL be granted on the following edge (no extra idle cycle).
REQ-023 When several req bits are high simultaneously, exactly one gnt bit SHALL assert; no gnt SHALL assert when no req is high.
REQ-024 Publishing a word equal to the current state_out SHALL still toggle upd_toggle and run a full HOLD.
REQ-025 cnt SHALL be 8 bits wide; ptr SHALL be ceil(log2(NREQ)) bits wide and SHALL never take values >= NREQ.
REQ-026 All outputs SHALL be registered; no combinational path SHALL exist from req to gnt.

Reset
REQ-027 While rst_n is low at an edge, the block SHALL set: FSM=IDLE, cnt=0, ptr=0, state_out=0, upd_toggle=0, gnt=0, busy=0.
REQ-028 rst_n asserted mid-HOLD SHALL abort the publish; outputs SHALL take their reset values on that edge, and no gnt SHALL follow.
REQ-029 The first edge with rst_n high SHALL be a normal IDLE evaluation cycle.

Verification
REQ-030 Single request: req=001, data0=8'hA5 -> next cycle gnt=001, state_out=A5, upd_toggle=1, busy=1; busy=0 after 4 cycles; state_out held.
REQ-031 Contention: req=111 held, data=11/22/33 -> grants in order 001, 010, 100, 001; grants 5 cycles apart; state_out 11, 22, 33, 11.
REQ-032 Hold blocking: req1 asserted 1 cycle after a grant to req0 -> gnt[1] exactly 5 cycles after gnt[0]; state_out unchanged in between.
REQ-033 Withdrawal: req2 pulsed high only during HOLD of another grant -> no gnt[2]; upd_toggle flips once.
REQ-034 Reset mid-HOLD: rst_n low 2 cycles after a grant of 8'h7E -> state_out=00, busy=0, ptr=0; next req=010 -> gnt=010.
REQ-035 Equal data: publish 8'h3C twice from req0 -> upd_toggle returns to 0; state_out=3C throughout.

Source files
------------

// File: rtl/state_publish_arb.sv
// Round-robin arbiter that publishes one requester's state word at a time and
// holds it stable for HOLD cycles so a slower clock domain can sample it safely.
module state_publish_arb #(
    parameter int BITS = 8,
    parameter int NREQ = 3,
    parameter int HOLD = 4
) (
    input  logic                 clk_50,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BITS-1:0] req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic [BITS-1:0]      state_out,
    output logic                 upd_toggle
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_cnt;
    logic [7:0]      w_cnt_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_nxt;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_idx;
    logic [PW:0]     w_sum;
    logic            w_found;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [NREQ-1:0] w_win_vec;
    logic [BITS-1:0] r_state_out;
    logic [BITS-1:0] w_state_out_nxt;
    logic [BITS-1:0] w_win_data;
    logic            r_busy;
    logic            r_toggle;
    logic            w_toggle_nxt;

    // Round-robin search: first active request at or above ptr, wrapping at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_idx = PW'(w_sum - (PW+1)'(NREQ));
            end else begin
                w_idx = PW'(w_sum);
            end
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Decode the winner index into a one-hot grant and its data slice.
    always_comb begin
        w_win_vec  = '0;
        w_win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PW'(i)) begin
                w_win_vec[i] = 1'b1;
                w_win_data   = req_data[i*BITS +: BITS];
            end else begin
                w_win_vec[i] = 1'b0;
            end
        end
    end

    // Next-state and next-output logic; grants are only considered in IDLE.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_ptr_nxt       = r_ptr;
        w_gnt_nxt       = '0;
        w_state_out_nxt = r_state_out;
        w_toggle_nxt    = r_toggle;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = ST_HOLD;
                    w_cnt_nxt       = 8'(HOLD - 1);
                    w_gnt_nxt       = w_win_vec;
                    w_state_out_nxt = w_win_data;
                    w_toggle_nxt    = ~r_toggle;
                    w_ptr_nxt       = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_state_out <= '0;
            r_toggle    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_state_out <= w_state_out_nxt;
            r_toggle    <= w_toggle_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign gnt        = r_gnt;
    assign busy       = r_busy;
    assign state_out  = r_state_out;
    assign upd_toggle = r_toggle;

endmodule

// File: tb/tb_state_publish_arb.sv
// Directed self-checking bench for state_publish_arb (BITS=8, NREQ=3, HOLD=4).
module tb_state_publish_arb;

    logic        clk_50;
    logic        rst_n;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic [2:0]  gnt;
    logic        busy;
    logic [7:0]  state_out;
    logic        upd_toggle;

    int checks   = 0;
    int failures = 0;
    logic exp_tog;
    logic [2:0] g_exp [4];
    logic [7:0] d_exp [4];

    state_publish_arb #(.BITS(8), .NREQ(3), .HOLD(4)) dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .busy      (busy),
        .state_out (state_out),
        .upd_toggle(upd_toggle)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    task automatic step;
        @(posedge clk_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 3'b000;
        req_data = 24'h000000;
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_state", 32'(state_out), 32'h0);
        chk("rst_tog", 32'(upd_toggle), 32'h0);
        rst_n = 1'b1;

        // Single request
        req_data[7:0] = 8'hA5;
        req = 3'b001;
        step();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_state", 32'(state_out), 32'hA5);
        chk("single_tog", 32'(upd_toggle), 32'h1);
        chk("single_busy", 32'(busy), 32'h1);
        req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("single_busy_hold", 32'(busy), 32'h1);
            chk("single_gnt_pulse", 32'(gnt), 32'h0);
        end
        step();
        chk("single_busy_end", 32'(busy), 32'h0);
        chk("single_state_held", 32'(state_out), 32'hA5);

        // Contention with all three requesters held high
        do_reset();
        exp_tog  = 1'b0;
        req_data = {8'h33, 8'h22, 8'h11};
        req      = 3'b111;
        g_exp    = '{3'b001, 3'b010, 3'b100, 3'b001};
        d_exp    = '{8'h11, 8'h22, 8'h33, 8'h11};
        for (int g = 0; g < 4; g++) begin
            step();
            exp_tog = ~exp_tog;
            chk("rr_gnt", 32'(gnt), 32'(g_exp[g]));
            chk("rr_state", 32'(state_out), 32'(d_exp[g]));
            chk("rr_tog", 32'(upd_toggle), 32'(exp_tog));
            if (g == 3) req = 3'b000;
            for (int j = 0; j < 4; j++) begin
                step();
                chk("rr_gap_gnt", 32'(gnt), 32'h0);
                chk("rr_gap_state", 32'(state_out), 32'(d_exp[g]));
            end
        end
        chk("rr_idle_busy", 32'(busy), 32'h0);

        // Request arriving during HOLD waits for the next IDLE cycle
        req_data[7:0] = 8'h44;
        req = 3'b001;
        step();
        exp_tog = ~exp_tog;
        chk("blk_gnt0", 32'(gnt), 32'h1);
        chk("blk_state0", 32'(state_out), 32'h44);
        req = 3'b010;
        req_data[15:8] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("blk_gap_gnt", 32'(gnt), 32'h0);
            chk("blk_gap_state", 32'(state_out), 32'h44);
        end
        step();
        exp_tog = ~exp_tog;
        chk("blk_gnt1", 32'(gnt), 32'h2);
        chk("blk_state1", 32'(state_out), 32'h55);
        chk("blk_tog", 32'(upd_toggle), 32'(exp_tog));
        req = 3'b000;
        repeat (4) step();

        // Withdrawal: req2 only high during another grant's HOLD
        req_data[7:0] = 8'h66;
        req = 3'b001;
        step();
        exp_tog = ~exp_tog;
        chk("wd_gnt0", 32'(gnt), 32'h1);
        chk("wd_tog0", 32'(upd_toggle), 32'(exp_tog));
        req = 3'b100;
        req_data[23:16] = 8'h77;
        step();
        req = 3'b000;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("wd_gnt", 32'(gnt), 32'h0);
            chk("wd_state", 32'(state_out), 32'h66);
            chk("wd_tog", 32'(upd_toggle), 32'(exp_tog));
        end

        // Reset in the middle of HOLD
        req_data[7:0] = 8'h7E;
        req = 3'b001;
        step();
        chk("rh_gnt", 32'(gnt), 32'h1);
        chk("rh_state", 32'(state_out), 32'h7E);
        req = 3'b000;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("rh_rst_state", 32'(state_out), 32'h0);
        chk("rh_rst_busy", 32'(busy), 32'h0);
        chk("rh_rst_gnt", 32'(gnt), 32'h0);
        chk("rh_rst_tog", 32'(upd_toggle), 32'h0);
        rst_n = 1'b1;
        req = 3'b011;
        req_data[15:8] = 8'h5A;
        step();
        chk("rh_ptr0_gnt", 32'(gnt), 32'h1);
        chk("rh_ptr0_state", 32'(state_out), 32'h7E);
        chk("rh_ptr0_tog", 32'(upd_toggle), 32'h1);
        req = 3'b000;
        repeat (4) step();
        req = 3'b010;
        step();
        chk("rh_gnt1", 32'(gnt), 32'h2);
        chk("rh_state1", 32'(state_out), 32'h5A);
        chk("rh_tog1", 32'(upd_toggle), 32'h0);
        req = 3'b000;
        repeat (4) step();

        // Equal data published twice by a requester that keeps req high
        do_reset();
        req_data[7:0] = 8'h3C;
        req = 3'b001;
        step();
        chk("eq_gnt0", 32'(gnt), 32'h1);
        chk("eq_state0", 32'(state_out), 32'h3C);
        chk("eq_tog0", 32'(upd_toggle), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("eq_gap_gnt", 32'(gnt), 32'h0);
            chk("eq_gap_state", 32'(state_out), 32'h3C);
        end
        step();
        chk("eq_gnt1", 32'(gnt), 32'h1);
        chk("eq_state1", 32'(state_out), 32'h3C);
        chk("eq_tog1", 32'(upd_toggle), 32'h0);
        req = 3'b000;
        repeat (4) step();
        chk("eq_busy_end", 32'(busy), 32'h0);
        chk("eq_state_end", 32'(state_out), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
